fifo_rr_writer_arb: RTL and testbench
=====================================

// Module: fifo_rr_writer_arb
// PURPOSE
//  Round-robin arbiter that shares one write port of a credit-controlled FIFO (e.g. fifo_w4) among N_REQ requesters.
//  Tracks downstream free space with a credit counter: one credit per beat written, one returned per beat read by the consumer.
//  Bursts are atomic: once a requester wins, it keeps the port until its beat with req_last=1.
//  Sits between producer channels and the shared FIFO write side; never writes into a full FIFO.
// PARAMETERS
//  WIDTH    32  data width per beat
//  N_REQ    4   number of requesters, 2..8
//  CREDITS  4   downstream FIFO capacity in beats, 1..15
// PORTS
//  clk          in   1             clock, all logic on posedge
//  reset_p      in   1             synchronous active-high reset
//  req_valid    in   N_REQ         per-requester beat valid
//  req_last     in   N_REQ         per-requester last beat of burst
//  req_data     in   N_REQ*WIDTH   requester i owns bits [i*WIDTH +: WIDTH]
//  req_ready    out  N_REQ         beat accepted this cycle (combinational, one-hot or zero)
//  fifo_data    out  WIDTH         registered write data to FIFO data_i
//  fifo_we      out  1             registered write strobe to FIFO data_we
//  credit_ret   in   1             consumer popped one beat (one credit back)
//  credit_cnt   out  $clog2(CREDITS+1)  free credits
//  grant_id     out  $clog2(N_REQ) current/last winner
//  busy         out  1             1 while in BURST
//  err_credit   out  1             sticky: credit_ret received with credit_cnt==CREDITS
// BEHAVIOUR
//  Reset (reset_p=1 at posedge): state=IDLE, credit_cnt=CREDITS, rr_ptr=0, grant_id=0, fifo_we=0, fifo_data=0, busy=0, err_credit=0.
//  While reset_p=1: req_ready=0. Reset mid-burst abandons the burst; no further writes.
//  Accept condition: req_ready[i]=1 and req_valid[i]=1 and credit_cnt>0; a beat is accepted only then.
//  IDLE: winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap at N_REQ-1 -> 0.
//    If credit_cnt>0, req_ready[winner]=1 and beat accepted; grant_id<=winner.
//    Accepted beat with req_last=0 -> BURST (locked to winner); with req_last=1 -> stay IDLE, rr_ptr<=winner+1 (mod N_REQ).
//  BURST: req_ready only to grant_id, only when credit_cnt>0; other requesters are ignored even if valid.
//    Accepted beat with req_last=1 -> IDLE, rr_ptr<=grant_id+1 (mod N_REQ). No valid or no credit -> hold BURST.
//  Write latency: accepted beat appears on fifo_data with fifo_we=1 exactly 1 cycle later; fifo_we=0 otherwise; fifo_data holds last value.
//  Credits: accept only -> cnt-1; credit_ret only -> cnt+1; both same cycle -> unchanged.
//    credit_ret at cnt==CREDITS with no accept -> cnt unchanged, err_credit<=1 (cleared only by reset).
//    cnt==0 -> req_ready all 0; cnt never underflows.
//  busy = (state==BURST). Max one beat per cycle; throughput 1 beat/clk while credits are available.
// TESTING
//  1 Reset then idle: credit_cnt=4, fifo_we=0, req_ready=0, err_credit=0.
//  2 All 4 requesters valid, single-beat bursts (last=1), credit_ret each cycle -> grants 0,1,2,3,0 in consecutive cycles; fifo_we each cycle, 1-cycle latency.
//  3 Req 2 sends 3-beat burst while req 0 valid -> beats 2a,2b,2c contiguous on fifo_data, then req 0 granted.
//  4 No credit_ret, req 1 streams 6 beats -> exactly 4 written, credit_cnt=0, req_ready=0; one credit_ret -> 5th beat accepted next cycle.
//  5 Accept and credit_ret same cycle at cnt=2 -> cnt stays 2; credit_ret at cnt=4 -> err_credit=1, cnt=4.
//  6 reset_p=1 mid-burst (beat 2 of 3) -> next cycle IDLE, cnt=4, fifo_we=0, rr_ptr=0 (req 0 wins first).

Source files
------------

// File: rtl/fifo_rr_writer_arb.sv
// Round-robin arbiter sharing one credit-controlled FIFO write port.
// Bursts are atomic; writes are registered one cycle after accept.
module fifo_rr_writer_arb #(
  parameter int WIDTH   = 32,
  parameter int N_REQ   = 4,
  parameter int CREDITS = 4
) (
  input  logic                     clk,
  input  logic                     reset_p,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]         fifo_data,
  output logic                     fifo_we,
  input  logic                     credit_ret,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     err_credit
);
  localparam int CW = $clog2(CREDITS+1);
  localparam int GW = $clog2(N_REQ);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic            we_q, we_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic            err_q, err_d;

  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic [GW-1:0]   sel;
  logic            accept;
  logic            sel_last;
  logic [WIDTH-1:0] sel_data;
  int              t;

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    t         = 0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      t = int'(rr_ptr_q) + k;
      if (t >= N_REQ) t = t - N_REQ;
      if (req_valid[t]) begin
        win_found = 1'b1;
        win_idx   = GW'(t);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel = (state_q == S_BURST) ? grant_q : win_idx;
    if (!reset_p && credit_q != '0) begin
      if (state_q == S_BURST)
        req_ready[grant_q] = 1'b1;
      else if (win_found)
        req_ready[win_idx] = 1'b1;
    end
    accept = |(req_ready & req_valid);
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (GW'(i) == sel) begin
        sel_last = req_last[i];
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    we_d     = accept;
    data_d   = accept ? sel_data : data_q;
    err_d    = err_q;
    if (accept) begin
      grant_d = sel;
      if (sel_last) begin
        state_d  = S_IDLE;
        rr_ptr_d = (sel == GW'(N_REQ-1)) ? '0 : sel + GW'(1);
      end else begin
        state_d = S_BURST;
      end
    end
    // A return with no room to grow the count is a consumer bug.
    if (accept && !credit_ret)
      credit_d = credit_q - CW'(1);
    else if (credit_ret && !accept) begin
      if (credit_q == CW'(CREDITS))
        err_d = 1'b1;
      else
        credit_d = credit_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q  <= S_IDLE;
      credit_q <= CW'(CREDITS);
      rr_ptr_q <= '0;
      grant_q  <= '0;
      we_q     <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign fifo_data  = data_q;
  assign fifo_we    = we_q;
  assign credit_cnt = credit_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q == S_BURST);
  assign err_credit = err_q;
endmodule

// File: tb/tb_fifo_rr_writer_arb.sv
// Directed bench for fifo_rr_writer_arb.
// Inputs change at posedge+1, outputs sampled before the next edge.
module tb_fifo_rr_writer_arb;
  logic         clk;
  logic         reset_p;
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [31:0]  fifo_data;
  logic         fifo_we;
  logic         credit_ret;
  logic [2:0]   credit_cnt;
  logic [1:0]   grant_id;
  logic         busy;
  logic         err_credit;

  int total;
  int bad;

  fifo_rr_writer_arb #(
    .WIDTH(32), .N_REQ(4), .CREDITS(4)
  ) dut (
    .clk(clk),
    .reset_p(reset_p),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_data(fifo_data),
    .fifo_we(fifo_we),
    .credit_ret(credit_ret),
    .credit_cnt(credit_cnt),
    .grant_id(grant_id),
    .busy(busy),
    .err_credit(err_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    req_data[i*32 +: 32] = v;
  endtask

  int exp_ids [5] = '{0, 1, 2, 3, 0};
  logic [31:0] d1;

  initial begin
    total = 0;
    bad = 0;
    reset_p = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    credit_ret = 1'b0;
    tick();
    tick();
    reset_p = 1'b0;
    tick();

    // 1: reset state
    check("rst_cnt", credit_cnt, 4);
    check("rst_we", fifo_we, 0);
    check("rst_rdy", req_ready, 0);
    check("rst_err", err_credit, 0);
    check("rst_busy", busy, 0);
    check("rst_gid", grant_id, 0);

    // 2: all valid, single beats, rotate 0,1,2,3,0
    req_valid = 4'hf;
    req_last = 4'hf;
    for (int i = 0; i < 4; i++) set_data(i, 32'hA0 + i);
    credit_ret = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_rdy", req_ready, 64'd1 << exp_ids[k]);
      tick();
      check("rr_we", fifo_we, 1);
      check("rr_data", fifo_data, 32'hA0 + exp_ids[k]);
      check("rr_gid", grant_id, exp_ids[k]);
      check("rr_cnt", credit_cnt, 4);
    end
    req_valid = '0;
    credit_ret = 1'b0;
    tick();
    check("rr_idle_we", fifo_we, 0);
    check("rr_idle_err", err_credit, 0);

    // 3: req 2 burst of 3 while req 0 waits (rr_ptr=1)
    req_valid = 4'b0101;
    req_last = 4'b0001;
    set_data(0, 32'hC0);
    credit_ret = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_data(2, 32'hB0 + k);
      if (k == 2) req_last = 4'b0101;
      #1;
      check("bu_rdy", req_ready, 4'b0100);
      tick();
      check("bu_data", fifo_data, 32'hB0 + k);
      check("bu_we", fifo_we, 1);
      check("bu_busy", busy, (k < 2) ? 1 : 0);
    end
    req_valid = 4'b0001;
    #1;
    check("bu_rdy0", req_ready, 4'b0001);
    tick();
    check("bu_data0", fifo_data, 32'hC0);
    check("bu_gid0", grant_id, 0);
    req_valid = '0;
    credit_ret = 1'b0;
    tick();
    check("bu_cnt", credit_cnt, 4);

    // 4: credit exhaustion, req 1 streams (rr_ptr=1)
    req_valid = 4'b0010;
    req_last = 4'b0000;
    d1 = 32'hD0;
    set_data(1, d1);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cr_rdy", req_ready, 4'b0010);
      tick();
      check("cr_data", fifo_data, d1);
      check("cr_cnt", credit_cnt, 3 - k);
      d1 = d1 + 1;
      set_data(1, d1);
    end
    #1;
    check("cr_rdy0", req_ready, 0);
    tick();
    check("cr_we0", fifo_we, 0);
    check("cr_cnt0", credit_cnt, 0);
    credit_ret = 1'b1;
    #1;
    check("cr_rdy1", req_ready, 0);
    tick();
    check("cr_cnt1", credit_cnt, 1);
    check("cr_we1", fifo_we, 0);
    credit_ret = 1'b0;
    req_last = 4'b0010;
    #1;
    check("cr_rdy5", req_ready, 4'b0010);
    tick();
    check("cr_we5", fifo_we, 1);
    check("cr_data5", fifo_data, 32'hD4);
    check("cr_cnt5", credit_cnt, 0);
    check("cr_busy5", busy, 0);
    req_valid = '0;
    credit_ret = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    credit_ret = 1'b0;
    check("cr_refill", credit_cnt, 4);
    check("cr_err", err_credit, 0);

    // 5: simultaneous accept+return, overflow error (rr_ptr=2)
    req_valid = 4'b1000;
    req_last = 4'b1000;
    set_data(3, 32'hE0);
    tick();
    set_data(3, 32'hE1);
    tick();
    check("ov_cnt2", credit_cnt, 2);
    set_data(3, 32'hE2);
    credit_ret = 1'b1;
    tick();
    check("ov_same", credit_cnt, 2);
    check("ov_data", fifo_data, 32'hE2);
    req_valid = '0;
    tick();
    tick();
    check("ov_cnt4", credit_cnt, 4);
    check("ov_err0", err_credit, 0);
    tick();
    check("ov_err1", err_credit, 1);
    check("ov_cnt", credit_cnt, 4);
    credit_ret = 1'b0;
    tick();
    check("ov_sticky", err_credit, 1);

    // 6: reset mid-burst (rr_ptr=0 -> 2 first)
    req_valid = 4'b0010;
    req_last = 4'b0010;
    set_data(1, 32'hF9);
    tick();
    req_valid = 4'b0100;
    req_last = 4'b0000;
    set_data(2, 32'hF0);
    tick();
    set_data(2, 32'hF1);
    tick();
    check("rs_busy", busy, 1);
    check("rs_cnt1", credit_cnt, 1);
    reset_p = 1'b1;
    set_data(2, 32'hF2);
    #1;
    check("rs_rdy", req_ready, 0);
    tick();
    reset_p = 1'b0;
    check("rs_state", busy, 0);
    check("rs_cnt", credit_cnt, 4);
    check("rs_we", fifo_we, 0);
    check("rs_err", err_credit, 0);
    check("rs_data", fifo_data, 0);
    req_valid = 4'b0101;
    req_last = 4'b0101;
    set_data(0, 32'h60);
    #1;
    check("rs_rdy0", req_ready, 4'b0001);
    tick();
    check("rs_data0", fifo_data, 32'h60);
    check("rs_gid0", grant_id, 0);
    req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
